// File: rtl/puf_hd_engine.sv
// puf_hd_engine
//   Hamming-distance engine for PUF response analysis. Accepts a pair of
//   WIDTH-bit hashes, popcounts their XOR serially CHUNK bits per cycle, and
//   presents the distance on a valid/ready output. It also keeps a saturating
//   running sum of distances and a count of delivered pairs. The average HD is
//   acc_sum / (pair_count * WIDTH).
//
// Ports
//   clk, rst              clock; synchronous active-high reset
//   in_valid / in_ready   input handshake (in_ready is high only in IDLE)
//   resp_a, resp_b        the two PUF hashes to compare
//   out_valid / out_ready output handshake for hd_count
//   hd_count              number of differing bits (0..WIDTH)
//   clear_acc             synchronous clear of acc_sum, pair_count and sat
//   acc_sum, pair_count   saturating accumulators, updated on output handshake
//   sat                   sticky flag: an accumulator clamped
//   busy                  engine is not idle
module puf_hd_engine #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned CHUNK = 8,
  parameter int unsigned ACC_W = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           resp_a,
  input  logic [WIDTH-1:0]           resp_b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(WIDTH+1)-1:0] hd_count,
  input  logic                       clear_acc,
  output logic [ACC_W-1:0]           acc_sum,
  output logic [CNT_W-1:0]           pair_count,
  output logic                       sat,
  output logic                       busy
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned HD_W   = $clog2(WIDTH + 1);
  localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("puf_hd_engine: WIDTH must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COUNT,
    ST_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] diff;
  logic [IDX_W-1:0] idx;

  function automatic logic [HD_W-1:0] popcount(input logic [CHUNK-1:0] v);
    logic [HD_W-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      n = n + HD_W'(v[i]);
    end
    return n;
  endfunction

  // Main FSM. The handshake flags are registered and change on the same edges
  // as the state transitions, so they always agree with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      diff      <= '0;
      idx       <= '0;
      hd_count  <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            diff     <= resp_a ^ resp_b;
            hd_count <= '0;
            idx      <= '0;
            state    <= ST_COUNT;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ST_COUNT: begin
          hd_count <= hd_count + popcount(diff[CHUNK-1:0]);
          diff     <= diff >> CHUNK;
          idx      <= idx + IDX_W'(1);
          if (idx == IDX_W'(NCHUNK - 1)) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // Accumulators. A clear coincident with a handshake zeroes the base first
  // and then adds the current result.
  logic [ACC_W-1:0] acc_base;
  logic [CNT_W-1:0] cnt_base;
  logic             sat_base;
  logic [ACC_W:0]   sum_ext;
  logic [CNT_W:0]   cnt_ext;

  always_comb begin
    acc_base = clear_acc ? '0 : acc_sum;
    cnt_base = clear_acc ? '0 : pair_count;
    sat_base = clear_acc ? 1'b0 : sat;
    sum_ext  = {1'b0, acc_base} + (ACC_W + 1)'(hd_count);
    cnt_ext  = {1'b0, cnt_base} + (CNT_W + 1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_sum    <= '0;
      pair_count <= '0;
      sat        <= 1'b0;
    end else if (out_valid && out_ready) begin
      acc_sum    <= sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
      pair_count <= cnt_ext[CNT_W] ? '1 : cnt_ext[CNT_W-1:0];
      sat        <= sat_base | sum_ext[ACC_W] | cnt_ext[CNT_W];
    end else if (clear_acc) begin
      acc_sum    <= '0;
      pair_count <= '0;
      sat        <= 1'b0;
    end
  end

endmodule

// File: tb/tb_puf_hd_engine.sv
// Testbench for puf_hd_engine. A default instance and an ACC_W=8 instance
// share all inputs; expected distances are queued when a pair is driven and
// compared when the output handshake occurs.
module tb_puf_hd_engine;

  localparam int unsigned WIDTH = 128;
  localparam int unsigned HD_W  = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [WIDTH-1:0] resp_a, resp_b;
  logic             out_ready;
  logic             clear_acc;

  logic             in_ready, out_valid, sat, busy;
  logic [HD_W-1:0]  hd_count;
  logic [15:0]      acc_sum;
  logic [7:0]       pair_count;

  logic             in_ready8, out_valid8, sat8, busy8;
  logic [HD_W-1:0]  hd_count8;
  logic [7:0]       acc_sum8;
  logic [7:0]       pair_count8;

  always #5 clk = ~clk;

  puf_hd_engine #(.WIDTH(128), .CHUNK(8), .ACC_W(16), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .resp_a(resp_a), .resp_b(resp_b), .out_valid(out_valid),
    .out_ready(out_ready), .hd_count(hd_count), .clear_acc(clear_acc),
    .acc_sum(acc_sum), .pair_count(pair_count), .sat(sat), .busy(busy)
  );

  puf_hd_engine #(.WIDTH(128), .CHUNK(8), .ACC_W(8), .CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8),
    .resp_a(resp_a), .resp_b(resp_b), .out_valid(out_valid8),
    .out_ready(out_ready), .hd_count(hd_count8), .clear_acc(clear_acc),
    .acc_sum(acc_sum8), .pair_count(pair_count8), .sat(sat8), .busy(busy8)
  );

  int checks = 0;
  int errors = 0;
  int sb[$];

  // accumulator model
  int m_sum, m_cnt, m_sum8;
  bit m_sat, m_sat8;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_sum = 0; m_cnt = 0; m_sat = 0; m_sum8 = 0; m_sat8 = 0;
  endtask

  task automatic model_hs(input int hd, input bit clr);
    if (clr) model_clear();
    m_sum += hd;
    if (m_sum > 65535) begin m_sum = 65535; m_sat = 1; end
    m_sum8 += hd;
    if (m_sum8 > 255) begin m_sum8 = 255; m_sat8 = 1; end
    m_cnt++;
    if (m_cnt > 255) begin m_cnt = 255; m_sat = 1; m_sat8 = 1; end
  endtask

  task automatic check_acc(input string tag);
    check({tag, "_acc"}, 32'(acc_sum), m_sum);
    check({tag, "_cnt"}, 32'(pair_count), m_cnt);
    check({tag, "_sat"}, 32'(sat), 32'(m_sat));
    check({tag, "_acc8"}, 32'(acc_sum8), m_sum8);
    check({tag, "_sat8"}, 32'(sat8), 32'(m_sat8));
  endtask

  // Drive one pair, wait for the result, optionally stall the consumer, then
  // complete the output handshake (optionally with clear_acc).
  task automatic run_pair(input string tag, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input int hold, input bit clr);
    int n;
    int exp_hd;
    logic [HD_W-1:0] hd_seen;
    n = 0;
    while (!in_ready && n < 100) begin tick(); n++; end
    check({tag, "_in_ready"}, 32'(in_ready), 1);
    resp_a = a; resp_b = b; in_valid = 1'b1;
    sb.push_back($countones(a ^ b));
    tick();
    in_valid = 1'b0;
    check({tag, "_busy"}, 32'(busy), 1);
    n = 0;
    while (!out_valid && n < 100) begin tick(); n++; end
    check({tag, "_latency"}, n, 16);
    hd_seen = hd_count;
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_hold_valid"}, 32'(out_valid), 1);
      check({tag, "_hold_hd"}, 32'(hd_count), 32'(hd_seen));
      check({tag, "_hold_in_ready"}, 32'(in_ready), 0);
      check({tag, "_hold_cnt"}, 32'(pair_count), m_cnt);
      check({tag, "_hold_acc"}, 32'(acc_sum), m_sum);
    end
    exp_hd = (sb.size() > 0) ? sb.pop_front() : -1;
    check({tag, "_hd"}, 32'(hd_count), exp_hd);
    out_ready = 1'b1;
    clear_acc = clr;
    model_hs(exp_hd, clr);
    tick();
    out_ready = 1'b0;
    clear_acc = 1'b0;
    check({tag, "_out_valid_drop"}, 32'(out_valid), 0);
    check({tag, "_idle"}, 32'(in_ready), 1);
    check_acc(tag);
  endtask

  logic [WIDTH-1:0] pat, near, ones;

  initial begin
    pat  = 128'h8A6D_264C_D7AE_265E_4CBC_3A55_DAAD_A974;
    near = 128'h8ACD_264C_D7AE_265E_4CBC_3A55_DAAD_A974;
    ones = '1;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clear_acc = 1'b0;
    resp_a = '0; resp_b = '0;
    model_clear();
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_hd", 32'(hd_count), 0);
    check("rst_busy", 32'(busy), 0);
    check_acc("rst");

    // out_ready with nothing pending must not count
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_acc("idle_ready");

    run_pair("same", pat, pat, 0, 1'b0);
    run_pair("ones", '0, ones, 5, 1'b0);
    run_pair("near", near, pat, 0, 1'b0);
    check("sum3", 32'(acc_sum), 130);
    check("cnt3", 32'(pair_count), 3);
    run_pair("near_clr", near, pat, 0, 1'b1);
    check("clr_hs_sum", 32'(acc_sum), 2);
    check("clr_hs_cnt", 32'(pair_count), 1);

    // clear_acc alone
    clear_acc = 1'b1;
    model_clear();
    tick();
    clear_acc = 1'b0;
    check_acc("clr_alone");

    run_pair("sat_a", '0, ones, 0, 1'b0);
    run_pair("sat_b", ones, '0, 0, 1'b0);
    check("sat8_sum", 32'(acc_sum8), 255);
    check("sat8_flag", 32'(sat8), 1);
    check("sum16_256", 32'(acc_sum), 256);
    clear_acc = 1'b1;
    model_clear();
    tick();
    clear_acc = 1'b0;
    check_acc("sat_clr");

    // build some history, then reset at COUNT idx 7
    run_pair("pre_rst", pat, ~pat, 0, 1'b0);
    resp_a = pat; resp_b = near; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("mid_busy", 32'(busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_clear();
    check("mrst_in_ready", 32'(in_ready), 1);
    check("mrst_out_valid", 32'(out_valid), 0);
    check("mrst_hd", 32'(hd_count), 0);
    check("mrst_busy", 32'(busy), 0);
    check_acc("mrst");

    for (int k = 0; k < 4; k++) begin
      logic [WIDTH-1:0] ra, rb;
      ra = {$urandom, $urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom, $urandom};
      run_pair("rand", ra, rb, k % 2, 1'b0);
    end

    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
